// File: rtl/uart_receiver_if.sv
// Byte-side and serial-side signals of the 8N1 UART receiver.
// master = receiver, slave = line driver / byte consumer.
interface uart_receiver_if;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    modport master (
        input  rx,
        input  ready,
        output data,
        output valid,
        output frame_err,
        output overrun
    );

    modport slave (
        output rx,
        output ready,
        input  data,
        input  valid,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: rx -> byte on a valid/ready holding register, with frame_err/overrun pulses.
// Latency: valid 12 cycles after the start bit at one clock per bit; backpressure: a byte arriving while valid && !ready is dropped.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_receiver_if.master bus
);

    localparam int H  = (CLKS_PER_BIT - 1) / 2;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    // START is entered one cycle after t0, so H-1 puts the start sample at t0+H
    localparam logic [CW-1:0] CNT_HALF = CW'((H > 0) ? (H - 1) : 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    logic [1:0]    sync_q;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          cnt_zero;

    logic          good_stop, bad_stop, load, drop, accept;
    logic [7:0]    data_q;
    logic          valid_q, frame_err_q, overrun_q;

    assign rx_s     = sync_q[1];
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], bus.rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    if (H == 0) begin
                        state_d = DATA;
                        cnt_d   = CNT_BIT;
                        idx_d   = '0;
                    end else begin
                        state_d = START;
                        cnt_d   = CNT_HALF;
                    end
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s) begin
                    state_d = DATA;
                    cnt_d   = CNT_BIT;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shreg_d = {rx_s, shreg_q[7:1]};
                    cnt_d   = CNT_BIT;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (!cnt_zero)  cnt_d   = cnt_q - 1'b1;
                else if (rx_s)  state_d = IDLE;
                else            state_d = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        if (state_q == STOP && cnt_zero) begin
            good_stop = rx_s;
            bad_stop  = !rx_s;
        end
        accept = valid_q && bus.ready;
        load   = good_stop && (!valid_q || bus.ready);
        drop   = good_stop && valid_q && !bus.ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= bad_stop;
            overrun_q   <= drop;
            if (load) begin
                data_q  <= shreg_q;
                valid_q <= 1'b1;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at one and eight clocks per bit.
// Stimulus pushes expected events; per-instance monitors pop them as the DUT produces them.
module tb_uart_receiver;

    localparam int K_DATA = 0;
    localparam int K_FE   = 1;
    localparam int K_OV   = 2;

    typedef struct {
        int         inst;
        int         kind;
        logic [7:0] dat;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_receiver_if b1 ();
    uart_receiver_if b8 ();

    uart_receiver #(.CLKS_PER_BIT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    uart_receiver #(.CLKS_PER_BIT(8)) u8 (.clk(clk), .rst(rst), .bus(b8));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic observe(input int inst, input int kind, input logic [7:0] d, input int now);
        int idx = -1;
        foreach (exp_q[i])
            if (idx < 0 && exp_q[i].inst == inst && exp_q[i].kind == kind) idx = i;
        tests++;
        if (idx < 0) begin
            fails++;
            $display("FAIL unexpected_event inst%0d kind%0d: got data %02h at cycle %0d, required none",
                     inst, kind, d, now);
        end else begin
            if (kind == K_DATA) check($sformatf("data_inst%0d", inst), d, exp_q[idx].dat);
            if (exp_q[idx].cyc != 0)
                check($sformatf("cycle_inst%0d_kind%0d", inst, kind), now, exp_q[idx].cyc);
            exp_q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (b1.valid && b1.ready) observe(0, K_DATA, b1.data, cyc);
            if (b1.frame_err)         observe(0, K_FE,   b1.data, cyc);
            if (b1.overrun)           observe(0, K_OV,   b1.data, cyc);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b8.valid && b8.ready) observe(1, K_DATA, b8.data, cyc);
            if (b8.frame_err)         observe(1, K_FE,   b8.data, cyc);
            if (b8.overrun)           observe(1, K_OV,   b8.data, cyc);
        end
    end

    task automatic set_rx(input int inst, input logic v);
        if (inst == 0) b1.rx = v;
        else           b8.rx = v;
    endtask

    // Callers are aligned to posedge+1; these keep that alignment.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic resync();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs appear after the edge numbered start+3+H+9*CPB.
    task automatic send_frame(input int inst, input logic [7:0] b, input logic stop,
                              input int expk, input bit timed);
        int         cpb  = (inst == 0) ? 1 : 8;
        int         h    = (cpb - 1) / 2;
        logic [9:0] bits = {stop, b, 1'b0};
        if (expk >= 0)
            exp_q.push_back('{inst, expk, b, timed ? (cyc + 3 + h + 9 * cpb) : 0});
        for (int i = 0; i < 10; i++) begin
            set_rx(inst, bits[i]);
            idle(cpb);
        end
        set_rx(inst, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish before 2ms");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        int         n;
        logic [9:0] bits;
        b1.rx = 1'b1; b8.rx = 1'b1;
        b1.ready = 1'b1; b8.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_data1",  b1.data, 8'h00);
        check("rst_valid1", b1.valid, 1'b0);
        check("rst_fe1",    b1.frame_err, 1'b0);
        check("rst_ov1",    b1.overrun, 1'b0);
        check("rst_data8",  b8.data, 8'h00);
        check("rst_valid8", b8.valid, 1'b0);
        check("rst_fe8",    b8.frame_err, 1'b0);
        check("rst_ov8",    b8.overrun, 1'b0);
        resync();
        idle(2);

        // single byte, valid for exactly one cycle at start+12
        n = cyc;
        send_frame(0, 8'hA5, 1'b1, K_DATA, 1'b1);
        wait_cyc(n + 13);
        check("single_valid_one_cycle", b1.valid, 1'b0);
        check("single_data_hold", b1.data, 8'hA5);
        resync();
        idle(3);

        // back-to-back frames, deliveries 10 cycles apart
        send_frame(0, 8'h3C, 1'b1, K_DATA, 1'b1);
        send_frame(0, 8'hC3, 1'b1, K_DATA, 1'b1);
        idle(6);
        check("b2b_valid_low", b1.valid, 1'b0);
        check("b2b_last_data", b1.data, 8'hC3);

        // overrun: second byte dropped while first is unconsumed
        b1.ready = 1'b0;
        send_frame(0, 8'h11, 1'b1, K_DATA, 1'b0);
        idle(2);
        n = cyc;
        send_frame(0, 8'h22, 1'b1, K_OV, 1'b1);
        wait_cyc(n + 13);
        check("ovr_data_kept", b1.data, 8'h11);
        check("ovr_valid_kept", b1.valid, 1'b1);
        check("ovr_pulse_width", b1.overrun, 1'b0);
        resync();
        b1.ready = 1'b1;
        n = cyc;
        wait_cyc(n + 1);
        check("ovr_valid_cleared", b1.valid, 1'b0);
        resync();
        idle(2);

        // framing error then a held break, then a clean byte
        send_frame(0, 8'h5A, 1'b0, K_FE, 1'b1);
        set_rx(0, 1'b0);
        idle(20);
        check("fe_valid_low", b1.valid, 1'b0);
        set_rx(0, 1'b1);
        idle(4);
        send_frame(0, 8'h01, 1'b1, K_DATA, 1'b1);
        idle(6);
        check("fe_next_data", b1.data, 8'h01);

        // eight clocks per bit: 2-cycle glitch is a false start
        set_rx(1, 1'b0);
        idle(2);
        set_rx(1, 1'b1);
        idle(20);
        check("glitch_valid_low", b8.valid, 1'b0);
        check("glitch_data_untouched", b8.data, 8'h00);
        send_frame(1, 8'hFF, 1'b1, K_DATA, 1'b1);
        idle(4);
        check("slow_data_ff", b8.data, 8'hFF);

        // reset pulse while data bit 4 of 0x96 is being sampled
        n = cyc;
        bits = {1'b1, 8'h96, 1'b0};
        for (int i = 0; i < 7; i++) begin
            set_rx(0, bits[i]);
            idle(1);
        end
        rst = 1'b1;
        set_rx(0, 1'b1);
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_data",  b1.data, 8'h00);
        check("midrst_valid", b1.valid, 1'b0);
        check("midrst_fe",    b1.frame_err, 1'b0);
        check("midrst_ov",    b1.overrun, 1'b0);
        resync();
        idle(15);
        check("midrst_no_late_valid", b1.valid, 1'b0);
        send_frame(0, 8'h96, 1'b1, K_DATA, 1'b1);
        idle(6);
        check("midrst_next_data", b1.data, 8'h96);

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
